ship_heading: RTL
=================

SHIP_HEADING -- requirements
Module: ship_heading

Interface
REQ-001 SHALL have parameter WIDTH_ANGLE_STEPS, default 32: heading steps per full turn; power of 2, 8..256.
REQ-002 SHALL have parameter BTN_RATE, default 10: button samples per second.
REQ-003 SHALL have parameter DIVIDER, default 125_000: clocks per frame tick.
REQ-004 SHALL have parameter CLK_RATE, default 25_000_000: clock frequency in Hz.
REQ-005 SHALL have parameter CORDIC_ITER, default 16: CORDIC iterations, 12..17.
REQ-006 SHALL have port clk, input, 1 bit: the one clock; all logic on its rising edge.
REQ-007 SHALL have port resetN, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port L, input, 1 bit: rotate counter-clockwise (decrement heading).
REQ-009 SHALL have port R, input, 1 bit: rotate clockwise (increment heading).
REQ-010 SHALL have port angle_idx, output, clog2(WIDTH_ANGLE_STEPS) bits: current heading index.
REQ-011 SHALL have port sin_val, output, signed 18 bits (Q1.17): sine of the heading; positive means screen-down.
REQ-012 SHALL have port cos_val, output, signed 18 bits (Q1.17): cosine of the heading; positive means screen-right.
REQ-013 SHALL have port heading_upd, output, 1 bit: one-cycle pulse when new sin_val/cos_val are presented.

Function
REQ-014 SHALL define the heading angle as angle_idx*360/WIDTH_ANGLE_STEPS degrees.
REQ-015 SHALL count frame ticks: counter 0..DIVIDER-1, one tick on the cycle it wraps.
REQ-016 SHALL count button ticks: BTN_DIVIDER = CLK_RATE/DIVIDER/BTN_RATE; one button tick exactly every BTN_DIVIDER frame ticks.
REQ-017 SHALL on a button tick in IDLE: R only -> idx+1; L only -> idx-1; both or neither -> no step.
REQ-018 SHALL wrap angle_idx modulo WIDTH_ANGLE_STEPS: max+1 -> 0 and 0-1 -> max.
REQ-019 SHALL not step on a button tick outside IDLE; the step is deferred to the next button tick.
REQ-020 SHALL implement FSM IDLE -> LOAD (1 cycle) -> ITER (CORDIC_ITER cycles) -> DONE (1 cycle) -> IDLE, entering LOAD only on the cycle after a step.
REQ-021 SHALL in LOAD fold the angle into +/-45 degrees by quadrant/octant selection and record the output sign/swap.
REQ-022 SHALL run one rotation-mode CORDIC iteration per ITER cycle, using a constant atan table and a gain-precompensated x start of 0.607253*2^17.
REQ-023 SHALL keep internal x/y/z at 20 bits or more.
REQ-024 SHALL in DONE apply the sign/swap, saturate to +/-131071, and update sin_val, cos_val and angle_idx in the same cycle.
REQ-025 SHALL pulse heading_upd in that DONE cycle.
REQ-026 SHALL have a latency of CORDIC_ITER+3 cycles from step tick to heading_upd; outputs are otherwise held stable.
REQ-027 SHALL keep each result within +/-4 LSB of round(2^17*sin/cos), saturated to +/-131071.
REQ-028 SHALL make exact cardinal angles (0, 90, 180, 270 degrees) bypass CORDIC and output exact 0 / +/-131071, with the same latency.

Reset
REQ-029 SHALL while resetN=0 at a clock edge: angle_idx=0, sin_val=0, cos_val=131071, heading_upd=0, FSM=IDLE, both counters 0, button history cleared.
REQ-030 SHALL make reset mid-calculation abort it: no heading_upd, outputs return to their reset values.

Configuration
REQ-031 SHALL when macro HEADING_AUTOREPEAT_EN is defined: step on every button tick while the button is held.
REQ-032 SHALL when HEADING_AUTOREPEAT_EN is undefined: step only on a button tick where the button is held and was not held at the previous button tick (one step per press); L/R history updates every button tick.

Verification
Bench parameters: DIVIDER=4, CLK_RATE=400, BTN_RATE=10 (button tick every 40 clocks), WIDTH_ANGLE_STEPS=32, CORDIC_ITER=16.
REQ-033 SHALL check: reset release, no buttons -> angle_idx=0, sin=0, cos=131071, no heading_upd for 200 cycles.
REQ-034 SHALL check: R held 8 button ticks, macro defined -> angle_idx=8, sin=131071, cos=0; heading_upd exactly 19 cycles after each tick.
REQ-035 SHALL check: from idx 0, L for one tick -> angle_idx=31, sin=-25571+/-4, cos=128553+/-4.
REQ-036 SHALL check: L and R held together 5 ticks -> angle_idx unchanged, no heading_upd.
REQ-037 SHALL check: R held 5 ticks, macro undefined -> angle_idx=1; release one tick, press again -> 2.
REQ-038 SHALL check: resetN low 10 cycles into ITER -> no heading_upd, outputs at reset values next cycle.

Source files
------------

// File: rtl/ship_heading.sv
// Ship heading: L/R buttons step a heading index; a rotation CORDIC yields sin/cos.
// Define HEADING_AUTOREPEAT_EN to step on every button tick while a button is held.
module ship_heading #(
  parameter int WIDTH_ANGLE_STEPS = 32,
  parameter int BTN_RATE          = 10,
  parameter int DIVIDER           = 125_000,
  parameter int CLK_RATE          = 25_000_000,
  parameter int CORDIC_ITER       = 16
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic                                 L,
  input  logic                                 R,
  output logic [$clog2(WIDTH_ANGLE_STEPS)-1:0] angle_idx,
  output logic signed [17:0]                   sin_val,
  output logic signed [17:0]                   cos_val,
  output logic                                 heading_upd
);
  localparam int AW      = $clog2(WIDTH_ANGLE_STEPS);
  localparam int BTN_DIV = CLK_RATE / DIVIDER / BTN_RATE;
  localparam int FW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int BW      = (BTN_DIV > 1) ? $clog2(BTN_DIV) : 1;
  localparam int IW      = $clog2(CORDIC_ITER);
  // x/y carry 3 guard bits below Q1.17; x start is 0.607253 * 2^20
  localparam logic signed [23:0] X0 = 24'sd636751;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t               state, state_n;
  logic [FW-1:0]        frame_cnt;
  logic [BW-1:0]        btn_cnt;
  logic                 frame_tick, btn_tick;
  logic                 step;
  logic [AW-1:0]        tgt;
  logic [IW-1:0]        iter;
  logic signed [23:0]   x, y, xs, ys;
  logic signed [31:0]   z, at;
  logic [31:0]          theta, t2;
  logic [1:0]           quad;
  logic                 cardinal;
  logic signed [17:0]   sz, cz, s_mag, c_mag;

  function automatic logic signed [31:0] atan_tab(input logic [4:0] i);
    case (i)
      5'd0:    atan_tab = 32'sh2000_0000;
      5'd1:    atan_tab = 32'sh12E4_051E;
      5'd2:    atan_tab = 32'sh09FB_385B;
      5'd3:    atan_tab = 32'sh0511_11D4;
      5'd4:    atan_tab = 32'sh028B_0D43;
      5'd5:    atan_tab = 32'sh0145_D7E1;
      5'd6:    atan_tab = 32'sh00A2_F61E;
      5'd7:    atan_tab = 32'sh0051_7C55;
      5'd8:    atan_tab = 32'sh0028_BE53;
      5'd9:    atan_tab = 32'sh0014_5F2F;
      5'd10:   atan_tab = 32'sh000A_2F98;
      5'd11:   atan_tab = 32'sh0005_17CC;
      5'd12:   atan_tab = 32'sh0002_8BE6;
      5'd13:   atan_tab = 32'sh0001_45F3;
      5'd14:   atan_tab = 32'sh0000_A2FA;
      5'd15:   atan_tab = 32'sh0000_517D;
      5'd16:   atan_tab = 32'sh0000_28BE;
      default: atan_tab = 32'sh0000_0000;
    endcase
  endfunction

  function automatic logic signed [17:0] sat(input logic signed [23:0] v);
    logic signed [23:0] r;
    r = (v + 24'sd4) >>> 3;
    if (r > 24'sd131071)       sat = 18'sd131071;
    else if (r < -24'sd131071) sat = -18'sd131071;
    else                       sat = r[17:0];
  endfunction

  assign frame_tick = (frame_cnt == FW'(DIVIDER - 1));
  assign btn_tick   = frame_tick && (btn_cnt == BW'(BTN_DIV - 1));

`ifdef HEADING_AUTOREPEAT_EN
  assign step = btn_tick && (state == IDLE) && (R ^ L);
`else
  logic r_prev, l_prev;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_prev <= 1'b0;
      l_prev <= 1'b0;
    end else if (btn_tick) begin
      r_prev <= R;
      l_prev <= L;
    end
  end

  assign step = btn_tick && (state == IDLE) &&
                ((R && !L && !r_prev) || (L && !R && !l_prev));
`endif

  // Binary angle: full turn = 2^32; nearest quadrant is split off
  assign theta = {tgt, {(32-AW){1'b0}}};
  assign t2    = theta + 32'h2000_0000;

  assign xs = x >>> iter;
  assign ys = y >>> iter;
  assign at = atan_tab(5'(iter));

  assign sz    = cardinal ? 18'sd0 : sat(y);
  assign cz    = cardinal ? 18'sd131071 : sat(x);
  assign s_mag = quad[0] ? cz : sz;
  assign c_mag = quad[0] ? sz : cz;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (step) state_n = LOAD;
      LOAD:    state_n = ITER;
      ITER:    if (iter == IW'(CORDIC_ITER - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      frame_cnt   <= '0;
      btn_cnt     <= '0;
      tgt         <= '0;
      iter        <= '0;
      x           <= '0;
      y           <= '0;
      z           <= '0;
      quad        <= '0;
      cardinal    <= 1'b0;
      angle_idx   <= '0;
      sin_val     <= '0;
      cos_val     <= 18'sd131071;
      heading_upd <= 1'b0;
    end else begin
      frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
      if (frame_tick)
        btn_cnt <= (btn_cnt == BW'(BTN_DIV - 1)) ? '0 : btn_cnt + 1'b1;
      if (step)
        tgt <= R ? tgt + 1'b1 : tgt - 1'b1;
      heading_upd <= (state == DONE);
      unique case (state)
        LOAD: begin
          quad     <= t2[31:30];
          cardinal <= (t2[29:0] == 30'h2000_0000);
          z        <= $signed({2'b00, t2[29:0]}) - 32'sh2000_0000;
          x        <= X0;
          y        <= '0;
          iter     <= '0;
        end
        ITER: begin
          if (!z[31]) begin
            x <= x - ys;
            y <= y + xs;
            z <= z - at;
          end else begin
            x <= x + ys;
            y <= y - xs;
            z <= z + at;
          end
          iter <= iter + 1'b1;
        end
        DONE: begin
          angle_idx <= tgt;
          sin_val   <= quad[1] ? -s_mag : s_mag;
          cos_val   <= (quad[1] ^ quad[0]) ? -c_mag : c_mag;
        end
        default: ;
      endcase
    end
  end

endmodule
